// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter arbiter: data width, requester limit
// and the controller state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W      = 8;
    localparam int unsigned UART_ARB_MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        DRAIN
    } uart_arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational request picker: first set request at or after ptr (rr=1), or
// lowest set index (rr=0). Returns a one-hot grant, its index and a valid flag.
module uart_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               rr,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    int unsigned cand;

    // Walk the requesters once, starting at the rotation point, wrapping at NUM_REQ.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (rr ? 32'(ptr) : 32'd0) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid_c && req[IDX_W'(cand)]) begin
                valid_c                  = 1'b1;
                grant_c[IDX_W'(cand)]    = 1'b1;
                idx_c                    = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart8_tx_arbiter.sv
// Shares one 8-bit UART transmitter among NUM_REQ byte sources and sequences one frame
// per grant. Define UART8_TX_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module uart8_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             tx_complete,
    output logic                           active,
    output logic                           tx_en,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_in,
    input  logic                           tx_busy,
    input  logic                           tx_done
);

    uart_arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]       ack_d, complete_d;
    logic                     start_d, active_d;
    logic [UART_DATA_W-1:0]   tx_in_d;
    logic [IDX_W-1:0]         w_q, w_d;

    logic [NUM_REQ-1:0]       pick_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_valid;
    logic                     rr_mode;
    logic [IDX_W-1:0]         rr_ptr;
    logic                     grant_go;
    logic [UART_DATA_W-1:0]   data_arr [NUM_REQ];

    assign tx_en    = en;
    assign grant_go = (state_q == IDLE) && en && pick_valid && !tx_busy;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
        assign data_arr[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .rr      (rr_mode),
        .ptr     (rr_ptr),
        .req     (req),
        .grant_c (pick_grant),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

`ifdef UART8_TX_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign rr_mode = 1'b1;
    assign rr_ptr  = ptr_q;

    // Rotation point moves just past the most recent winner.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_go) begin
            ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign rr_mode = 1'b0;
    assign rr_ptr  = '0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        complete_d = '0;
        start_d    = 1'b0;
        active_d   = active;
        tx_in_d    = tx_in;
        w_d        = w_q;
        unique case (state_q)
            IDLE: begin
                if (grant_go) begin
                    ack_d    = pick_grant;
                    tx_in_d  = data_arr[pick_idx];
                    active_d = 1'b1;
                    w_d      = pick_idx;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                start_d = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that finishes before ever showing busy still completes the frame.
                if (tx_done) begin
                    complete_d = NUM_REQ'(1) << w_q;
                    active_d   = 1'b0;
                    state_d    = DRAIN;
                end else if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    complete_d = NUM_REQ'(1) << w_q;
                    active_d   = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack         <= '0;
            tx_complete <= '0;
            tx_start    <= 1'b0;
            active      <= 1'b0;
            tx_in       <= '0;
            w_q         <= '0;
        end else begin
            state_q     <= state_d;
            ack         <= ack_d;
            tx_complete <= complete_d;
            tx_start    <= start_d;
            active      <= active_d;
            tx_in       <= tx_in_d;
            w_q         <= w_d;
        end
    end

endmodule
